// File: rtl/key_remap_ctrl.sv
// Key remap controller: rebinds the key position of each of the eight note slots and publishes the live map.
// Latency: input rise -> registered edge -> state change, 2 clocks. The map and done update one clock after COMMIT.
// Backpressure: none. Edges are one-cycle events. Confirm edges are dropped outside WAIT_KEY, and start is dropped while busy.
module key_remap_ctrl #(
    parameter int unsigned ERR_CYCLES  = 50_000_000,
    parameter logic [23:0] DEFAULT_MAP = 24'hFAC688
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        confirm,
    input  logic        cancel,
    input  logic [7:0]  touch,
    output logic [23:0] anJian,
    output logic        busy,
    output logic [2:0]  cur_note,
    output logic [7:0]  used_mask,
    output logic        err,
    output logic        done
);

    localparam int CW = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ERR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_KEY = 3'd1,
        RELEASE  = 3'd2,
        ERR      = 3'd3,
        COMMIT   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [23:0]   anjian_q, anjian_d;
    logic [23:0]   work_q, work_d;
    logic [2:0]    cur_q, cur_d;
    logic [7:0]    used_q, used_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    logic start_q, confirm_q, cancel_q;
    logic start_edge_q, confirm_edge_q, cancel_edge_q;

    logic [2:0] key_idx;
    logic       key_ok;

    // Delay copies and registered rising-edge pulses of the control inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q        <= 1'b0;
            confirm_q      <= 1'b0;
            cancel_q       <= 1'b0;
            start_edge_q   <= 1'b0;
            confirm_edge_q <= 1'b0;
            cancel_edge_q  <= 1'b0;
        end else begin
            start_q        <= start;
            confirm_q      <= confirm;
            cancel_q       <= cancel;
            start_edge_q   <= start & ~start_q;
            confirm_edge_q <= confirm & ~confirm_q;
            cancel_edge_q  <= cancel & ~cancel_q;
        end
    end

    // Index of the pressed key. It is only meaningful when exactly one key is down.
    always_comb begin
        key_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (touch[i]) key_idx = 3'(i);
        end
        key_ok = $onehot(touch) && !used_q[key_idx];
    end

    // State, live map, working copy and session bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            anjian_q <= DEFAULT_MAP;
            work_q   <= DEFAULT_MAP;
            cur_q    <= 3'd0;
            used_q   <= 8'd0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            anjian_q <= anjian_d;
            work_q   <= work_d;
            cur_q    <= cur_d;
            used_q   <= used_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    // Session sequencing. Cancel takes priority over confirm, and the live map is written only from COMMIT.
    always_comb begin
        state_d  = state_q;
        anjian_d = anjian_q;
        work_d   = work_q;
        cur_d    = cur_q;
        used_d   = used_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge_q) begin
                    state_d = WAIT_KEY;
                    cur_d   = 3'd0;
                    used_d  = 8'd0;
                    work_d  = anjian_q;
                end
            end
            WAIT_KEY: begin
                if (cancel_edge_q) begin
                    state_d = IDLE;
                end else if (confirm_edge_q) begin
                    if (key_ok) begin
                        for (int i = 0; i < 8; i++) begin
                            if (cur_q == 3'(i)) work_d[3*i +: 3] = 3'd7 - key_idx;
                        end
                        used_d[key_idx] = 1'b1;
                        if (cur_q == 3'd7) begin
                            state_d = COMMIT;
                        end else begin
                            cur_d   = cur_q + 3'd1;
                            state_d = RELEASE;
                        end
                    end else begin
                        state_d = ERR;
                        cnt_d   = '0;
                    end
                end
            end
            RELEASE: begin
                if (cancel_edge_q)      state_d = IDLE;
                else if (touch == 8'd0) state_d = WAIT_KEY;
            end
            ERR: begin
                if (cancel_edge_q)          state_d = IDLE;
                else if (cnt_q == CNT_LAST) state_d = WAIT_KEY;
                else                        cnt_d   = cnt_q + 1'b1;
            end
            COMMIT: begin
                anjian_d = work_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign anJian    = anjian_q;
    assign busy      = (state_q != IDLE);
    assign cur_note  = cur_q;
    assign used_mask = used_q;
    assign err       = (state_q == ERR);
    assign done      = done_q;

endmodule

// File: tb/tb_key_remap_ctrl.sv
// Bench for key_remap_ctrl: directed scenarios followed by random sessions checked against a slot-level model.
// Latency: checks sample 1 time unit after the rising clock edge.
// Backpressure: not applicable.
module tb_key_remap_ctrl;
    localparam int ERRC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, confirm = 1'b0, cancel = 1'b0;
    logic [7:0]  touch = 8'd0;
    logic [23:0] anJian;
    logic        busy, err, done;
    logic [2:0]  cur_note;
    logic [7:0]  used_mask;

    key_remap_ctrl #(.ERR_CYCLES(ERRC), .DEFAULT_MAP(24'hFAC688)) dut (
        .clk(clk), .rst(rst), .start(start), .confirm(confirm), .cancel(cancel),
        .touch(touch), .anJian(anJian), .busy(busy), .cur_note(cur_note),
        .used_mask(used_mask), .err(err), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    // Reference model: per-slot key positions, the live map and session status.
    int       m_live[8];
    int       m_pos[8];
    int       m_cur;
    logic [7:0] m_used;
    int       m_done;
    bit       m_busy;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    function automatic logic [23:0] live_map();
        logic [23:0] r = 24'd0;
        for (int i = 0; i < 8; i++) r = r | (24'(m_live[i]) << (3 * i));
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin m_live[i] = i; m_pos[i] = i; end
        m_cur = 0; m_used = 8'd0; m_busy = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ".cur"}, 32'(cur_note), 32'(m_cur));
        chk({tag, ".used"}, 32'(used_mask), 32'(m_used));
        chk({tag, ".map"}, 32'(anJian), 32'(live_map()));
        chk({tag, ".done"}, 32'(done_cnt), 32'(m_done));
    endtask

    task automatic do_start();
        bit was_busy = m_busy;
        start = 1'b1;
        tick(1);
        if (!was_busy) chk("start_lat1", 32'(busy), 32'd0);
        tick(1);
        start = 1'b0;
        if (!was_busy) begin
            m_busy = 1; m_cur = 0; m_used = 8'd0;
            for (int i = 0; i < 8; i++) m_pos[i] = m_live[i];
        end
        tick(1);
        check_status("start");
    endtask

    task automatic press(input logic [7:0] t);
        int ones = 0;
        int b = 0;
        int ec = 0;
        bit ok;
        for (int i = 0; i < 8; i++) if (t[i]) begin ones++; b = i; end
        ok = (ones == 1) && !m_used[b];
        touch = t;
        confirm = 1'b1;
        tick(2);
        for (int k = 0; k < 20 && err === 1'b1; k++) begin ec++; tick(1); end
        chk("err_cycles", 32'(ec), ok ? 32'd0 : 32'(ERRC));
        confirm = 1'b0;
        touch = 8'd0;
        tick(3);
        if (ok) begin
            m_pos[m_cur] = 7 - b;
            m_used[b] = 1'b1;
            if (m_cur == 7) begin
                for (int i = 0; i < 8; i++) m_live[i] = m_pos[i];
                m_done++;
                m_busy = 0;
            end else begin
                m_cur++;
            end
        end
        check_status("press");
    endtask

    task automatic do_cancel(input bit with_confirm);
        logic [7:0] k = 8'h01;
        for (int i = 7; i >= 0; i--) if (!m_used[i]) k = 8'(1 << i);
        cancel = 1'b1;
        if (with_confirm) begin confirm = 1'b1; touch = k; end
        tick(2);
        cancel = 1'b0; confirm = 1'b0; touch = 8'd0;
        tick(2);
        m_busy = 0;
        check_status(with_confirm ? "cancel_conf" : "cancel");
    endtask

    initial begin
        model_reset();
        m_done = 0;
        #2 rst = 1'b0;
        #20;
        chk("rst.map", 32'(anJian), 32'h00FAC688);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.cur", 32'(cur_note), 32'd0);
        chk("rst.used", 32'(used_mask), 32'd0);
        @(negedge clk) rst = 1'b1;
        tick(2);

        // Full reverse remap
        do_start();
        for (int n = 0; n < 8; n++) press(8'(1 << n));
        chk("rev.map", 32'(anJian), 32'h00053977);
        chk("rev.used", 32'(used_mask), 32'hFF);
        chk("rev.done", 32'(done_cnt), 32'd1);

        // Duplicate key, then illegal presses, then finish the session
        do_start();
        press(8'h80);
        press(8'h80);
        chk("dup.cur", 32'(cur_note), 32'd1);
        chk("dup.used", 32'(used_mask), 32'h80);
        press(8'h40);
        press(8'h00);
        press(8'h03);
        for (int n = 5; n >= 0; n--) press(8'(1 << n));
        chk("ill.map", 32'(anJian), 32'h00FAC688);

        // Cancel after three slots, then simultaneous confirm and cancel
        do_start();
        press(8'h04); press(8'h10); press(8'h01);
        do_cancel(1'b0);
        chk("cancel.map", 32'(anJian), 32'h00FAC688);
        do_start();
        press(8'h02);
        do_cancel(1'b1);

        // Commit a reverse map, then reset mid-session
        do_start();
        for (int n = 0; n < 8; n++) press(8'(1 << n));
        do_start();
        press(8'h01);
        do_start();
        chk("busy_start.cur", 32'(cur_note), 32'd1);
        rst = 1'b0;
        #1;
        model_reset();
        chk("midrst.map", 32'(anJian), 32'h00FAC688);
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.cur", 32'(cur_note), 32'd0);
        chk("midrst.used", 32'(used_mask), 32'd0);
        @(negedge clk) rst = 1'b1;
        tick(2);

        // Random sessions
        for (int s = 0; s < 6; s++) begin
            do_start();
            for (int p = 0; p < 40 && m_busy; p++) begin
                int r = $urandom_range(0, 99);
                if (r < 4)       do_cancel(r < 2);
                else if (r < 75) press(8'(1 << $urandom_range(0, 7)));
                else             press(8'($urandom_range(0, 255)));
            end
            if (m_busy) do_cancel(1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
